// File: rtl/wb_regfile_pkg.sv
// Shared MEM/WB pipeline definitions: field widths and the writeback bundle.
package wb_regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // Registered writeback bundle as it leaves the MEM/WB pipeline register.
  typedef struct packed {
    logic                  regwrite;
    logic                  memtoreg;
    logic [REG_ADDR_W-1:0] dest;
    logic [XLEN-1:0]       memadd;
    logic [XLEN-1:0]       memdata;
  } wb_bundle;

endpackage

// File: rtl/wb_regfile_regfile_2r1w.sv
// Architectural register storage: one write port, two combinational read
// ports with write-first bypass, asynchronous clear.
module regfile_2r1w
  import wb_regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int XLEN     = wb_regfile_pkg::XLEN,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            res,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddrA,
  input  logic [AW-1:0]   raddrB,
  output logic [XLEN-1:0] rdataA,
  output logic [XLEN-1:0] rdataB
);

  logic [XLEN-1:0] mem [NREG];

  // Storage update: whole array clears on reset, otherwise one write per edge.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Reads: hard zero for r0, then same-cycle bypass of the pending write,
  // otherwise the stored value. Bypass needs we=1 so X on waddr is harmless.
  assign rdataA = ((ZERO_REG != 0) && (raddrA == '0)) ? '0 :
                  (we && (raddrA == waddr))           ? wdata : mem[raddrA];
  assign rdataB = ((ZERO_REG != 0) && (raddrB == '0)) ? '0 :
                  (we && (raddrB == waddr))           ? wdata : mem[raddrB];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage consumer: selects the writeback value, commits it into the
// register file, and publishes a one-cycle forwarding record plus a count of
// committed writes.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int XLEN     = wb_regfile_pkg::XLEN,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  iRegWrite,
  input  logic                  iMemtoReg,
  input  logic [REG_ADDR_W-1:0] iRegDest,
  input  logic [XLEN-1:0]       iMemAdd,
  input  logic [XLEN-1:0]       iMemData,
  input  logic [REG_ADDR_W-1:0] iRsAddr,
  input  logic [REG_ADDR_W-1:0] iRtAddr,
  output logic [XLEN-1:0]       oRsData,
  output logic [XLEN-1:0]       oRtData,
  output logic [XLEN-1:0]       oWbData,
  output logic                  oFwdValid,
  output logic [REG_ADDR_W-1:0] oFwdDest,
  output logic [XLEN-1:0]       oFwdData,
  output logic [31:0]           oWbCount
);

  logic                  commit;
  logic                  vld_p1;
  logic [REG_ADDR_W-1:0] fwdDest_p1;
  logic [XLEN-1:0]       fwdData_p1;
  logic [31:0]           wbCount_p1;

  // Writeback mux and commit qualifier; writes to r0 are dropped when it is
  // hardwired, and nothing but iRegWrite can enable a commit.
  assign oWbData = iMemtoReg ? iMemData : iMemAdd;
  assign commit  = iRegWrite && !((ZERO_REG != 0) && (iRegDest == '0));

  regfile_2r1w #(
    .NREG     (NREG),
    .XLEN     (XLEN),
    .ZERO_REG (ZERO_REG),
    .AW       (REG_ADDR_W)
  ) uRegs (
    .clk    (clk),
    .res    (res),
    .we     (commit),
    .waddr  (iRegDest),
    .wdata  (oWbData),
    .raddrA (iRsAddr),
    .raddrB (iRtAddr),
    .rdataA (oRsData),
    .rdataB (oRtData)
  );

  // ---- stage p1: forwarding record and committed-write counter ----
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      vld_p1     <= 1'b0;
      fwdDest_p1 <= '0;
      fwdData_p1 <= '0;
      wbCount_p1 <= '0;
    end else begin
      vld_p1     <= commit;
      fwdDest_p1 <= iRegDest;
      fwdData_p1 <= oWbData;
      if (commit) wbCount_p1 <= wbCount_p1 + 32'd1;
    end
  end

  assign oFwdValid = vld_p1;
  assign oFwdDest  = fwdDest_p1;
  assign oFwdData  = fwdData_p1;
  assign oWbCount  = wbCount_p1;

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed literal checks plus randomized traffic
// checked every cycle against an array-based model of the register file.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic        iRegWrite = 1'b0;
  logic        iMemtoReg = 1'b0;
  logic [4:0]  iRegDest = '0;
  logic [31:0] iMemAdd = '0;
  logic [31:0] iMemData = '0;
  logic [4:0]  iRsAddr = '0;
  logic [4:0]  iRtAddr = '0;
  logic [31:0] oRsData, oRtData, oWbData, oFwdData, oWbCount;
  logic        oFwdValid;
  logic [4:0]  oFwdDest;

  int nTests = 0;
  int nFail  = 0;

  // model state
  logic [31:0] mdl [32];
  logic [31:0] mdlCount;
  logic        mdlFwdValid;
  logic [4:0]  mdlFwdDest;
  logic [31:0] mdlFwdData;

  wb_regfile dut (
    .clk(clk), .res(res), .iRegWrite(iRegWrite), .iMemtoReg(iMemtoReg),
    .iRegDest(iRegDest), .iMemAdd(iMemAdd), .iMemData(iMemData),
    .iRsAddr(iRsAddr), .iRtAddr(iRtAddr), .oRsData(oRsData), .oRtData(oRtData),
    .oWbData(oWbData), .oFwdValid(oFwdValid), .oFwdDest(oFwdDest),
    .oFwdData(oFwdData), .oWbCount(oWbCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    mdlCount = '0; mdlFwdValid = 1'b0; mdlFwdDest = '0; mdlFwdData = '0;
  endtask

  function automatic logic [31:0] expWb();
    return iMemtoReg ? iMemData : iMemAdd;
  endfunction

  function automatic logic expCommit();
    return iRegWrite && (iRegDest != 5'd0);
  endfunction

  function automatic logic [31:0] expRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (expCommit() && a == iRegDest) return expWb();
    return mdl[a];
  endfunction

  // compare all outputs against the model for the currently applied inputs
  task automatic checkAll();
    chk("wbData", oWbData, expWb());
    chk("rsData", oRsData, expRead(iRsAddr));
    chk("rtData", oRtData, expRead(iRtAddr));
    chk("fwdValid", {31'd0, oFwdValid}, {31'd0, mdlFwdValid});
    chk("wbCount", oWbCount, mdlCount);
    if (mdlFwdValid) begin
      chk("fwdDest", {27'd0, oFwdDest}, {27'd0, mdlFwdDest});
      chk("fwdData", oFwdData, mdlFwdData);
    end
  endtask

  // model behaviour at a rising edge, using the inputs held across it
  task automatic modelEdge();
    logic c;
    logic [31:0] w;
    c = expCommit();
    w = expWb();
    if (c) begin
      mdl[iRegDest] = w;
      mdlCount = mdlCount + 32'd1;
    end
    mdlFwdValid = c;
    mdlFwdDest  = iRegDest;
    mdlFwdData  = w;
  endtask

  // called just after a falling edge with inputs applied
  task automatic cycle();
    #1 checkAll();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [4:0] dest,
                       input logic [31:0] add, input logic [31:0] data,
                       input logic [4:0] rs, input logic [4:0] rt);
    iRegWrite = we; iMemtoReg = m2r; iRegDest = dest;
    iMemAdd = add; iMemData = data; iRsAddr = rs; iRtAddr = rt;
  endtask

  initial begin
    modelReset();
    // reset state: every register reads zero
    #1;
    for (int i = 0; i < 32; i++) begin
      iRsAddr = 5'(i); iRtAddr = 5'(31 - i);
      #1;
      chk("rst_rs", oRsData, 32'd0);
      chk("rst_rt", oRtData, 32'd0);
    end
    chk("rst_cnt", oWbCount, 32'd0);
    chk("rst_vld", {31'd0, oFwdValid}, 32'd0);
    @(negedge clk);
    res = 1'b0;

    // write r5 = 0x1234 via ALU path
    drive(1'b1, 1'b0, 5'd5, 32'h0000_1234, 32'h9999_9999, 5'd1, 5'd2);
    cycle();
    drive(1'b0, 1'b0, 5'd9, 32'h0, 32'h0, 5'd5, 5'd5);
    #1;
    chk("r5_lit", oRsData, 32'h0000_1234);
    chk("fwdV_lit", {31'd0, oFwdValid}, 32'd1);
    chk("fwdD_lit", {27'd0, oFwdDest}, 32'd5);
    chk("fwdData_lit", oFwdData, 32'h0000_1234);
    chk("cnt1_lit", oWbCount, 32'd1);
    @(negedge clk);
    modelEdge();

    // same-cycle bypass on both ports
    drive(1'b1, 1'b1, 5'd7, 32'h1111_1111, 32'hDEAD_BEEF, 5'd7, 5'd7);
    #1;
    chk("byp_rs_lit", oRsData, 32'hDEAD_BEEF);
    chk("byp_rt_lit", oRtData, 32'hDEAD_BEEF);
    #1;
    cycle();

    // write to r0 is ignored
    drive(1'b1, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 5'd7);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd3);
    #1;
    chk("r0_lit", oRsData, 32'd0);
    chk("r0_vld_lit", {31'd0, oFwdValid}, 32'd0);
    chk("r0_cnt_lit", oWbCount, 32'd2);
    #1;
    cycle();

    // disabled write leaves r3 alone
    drive(1'b0, 1'b0, 5'd3, 32'h55, 32'h55, 5'd3, 5'd3);
    cycle();
    // write r3 = 0xAA, then reset mid-cycle
    drive(1'b1, 1'b0, 5'd3, 32'hAA, 32'h0, 5'd3, 5'd1);
    #1 checkAll();
    @(posedge clk);
    modelEdge();
    #2;
    iRegWrite = 1'b0;
    res = 1'b1;
    #1;
    chk("rst_r3_lit", oRsData, 32'd0);
    chk("rst_cnt_lit", oWbCount, 32'd0);
    modelReset();
    @(negedge clk);
    res = 1'b0;
    drive(1'b1, 1'b1, 5'd3, 32'h0, 32'h0000_0BAD, 5'd3, 5'd4);
    cycle();

    // counter wrap: preload via force, then one commit
    drive(1'b0, 1'b0, 5'd1, 32'h0, 32'h0, 5'd1, 5'd2);
    force dut.wbCount_p1 = 32'hFFFF_FFFF;
    #1;
    release dut.wbCount_p1;
    mdlCount = 32'hFFFF_FFFF;
    cycle();
    drive(1'b1, 1'b0, 5'd12, 32'h0C0C_0C0C, 32'h0, 5'd12, 5'd0);
    cycle();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 5'd12, 5'd0);
    #1;
    chk("wrap_lit", oWbCount, 32'd0);
    #1;
    cycle();

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [4:0] d;
      d = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), d,
            $urandom, $urandom,
            ($urandom_range(0, 1) == 0) ? d : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31)));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Consumer end of the MEM/WB pipeline register.
- Takes the registered writeback bundle (RegWrite, MemtoReg, RegDest, ALU result, load data) and selects the writeback value.
- Commits that value into the 32x32 architectural register file and serves the two decode-stage read ports, with same-cycle write-to-read bypass.
- Also exports a one-cycle-delayed forwarding record and a committed-write counter for the hazard unit and debug.

Parameters:
- NREG, 32, number of architectural registers; address width is log2(NREG).
- XLEN, 32, data width of registers and writeback operands.
- ZERO_REG, 1, when 1, register 0 reads as zero and ignores writes.

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- res  input  1  reset; asynchronous, active-high.
- iRegWrite  input  1  writeback enable from MEM/WB register.
- iMemtoReg  input  1  1 selects iMemData, 0 selects iMemAdd.
- iRegDest  input  5  destination register index.
- iMemAdd  input  XLEN  ALU result / address from MEM/WB.
- iMemData  input  XLEN  load data from MEM/WB.
- iRsAddr  input  5  decode read port A address.
- iRtAddr  input  5  decode read port B address.
- oRsData  output  XLEN  read port A data, combinational.
- oRtData  output  XLEN  read port B data, combinational.
- oWbData  output  XLEN  selected writeback value, combinational.
- oFwdValid  output  1  registered: a commit occurred last cycle.
- oFwdDest  output  5  registered destination of last commit.
- oFwdData  output  XLEN  registered data of last commit.
- oWbCount  output  32  count of committed writes.

Behaviour:
- Writeback select:
  - oWbData = iMemtoReg ? iMemData : iMemAdd.
  - Pure mux, no latency.
- Commit condition:
  - commit = iRegWrite && !(ZERO_REG && iRegDest==0).
  - On a rising clk edge with commit, regs[iRegDest] <= oWbData.
  - A write with iRegWrite=0 changes no state.
- Reads:
  - Combinational from the regs array.
  - Address 0 returns 0 when ZERO_REG=1.
- Bypass:
  - If commit and the read address equals iRegDest, the port returns oWbData in the same cycle.
  - This is write-first behaviour; it covers the 3-stage distance hazard.
  - Both ports may bypass simultaneously when both addresses match.
- Forwarding record:
  - Updated every edge: oFwdValid <= commit; oFwdDest <= iRegDest; oFwdData <= oWbData.
  - oFwdDest and oFwdData are only meaningful when oFwdValid=1.
  - Latency from commit to record: 1 cycle.
- Counter:
  - oWbCount increments by 1 on every edge with commit.
  - Wraps from 0xFFFFFFFF to 0; no saturation.
- Reset (async, res=1):
  - All regs = 0.
  - oFwdValid = 0, oFwdDest = 0, oFwdData = 0, oWbCount = 0.
  - Combinational outputs follow the cleared state immediately.
  - Reset asserted mid-write: the write is lost and the register reads 0.
  - The first edge after res deasserts may commit.
- Back-to-back writes to the same register: the last one wins each cycle, and the forward record reflects each in turn.
- X on iRegDest or iMemtoReg while iRegWrite=0 must not corrupt state.

Decomposition:
- Shared package (pipeline pkg), already holding the MEM/WB field widths, gains:
  - REG_ADDR_W = 5 and XLEN = 32.
  - A wb_bundle typedef {regwrite, memtoreg, dest, memadd, memdata}.
- One sub-module: regfile_2r1w, the storage array with async clear, two combinational read ports and internal bypass.
- wb_regfile holds the mux, commit logic, forward record and counter.

Test Plan:
- Reset then read r0..r31 -> all 0; oWbCount=0, oFwdValid=0.
- Write iRegDest=5, iMemtoReg=0, iMemAdd=0x0000_1234 -> the next cycle reads r5=0x1234; oFwdValid=1, oFwdDest=5, oFwdData=0x1234; oWbCount=1.
- Same-cycle bypass: iRegWrite=1, dest=7, iMemtoReg=1, iMemData=0xDEAD_BEEF, iRsAddr=iRtAddr=7 -> both ports read 0xDEADBEEF in that cycle.
- Write dest=0 with data 0xFFFF_FFFF -> r0 still reads 0, oFwdValid=0, counter unchanged.
- iRegWrite=0, dest=3, data 0x55 -> r3 unchanged, oWbCount unchanged; then assert res mid-cycle after writing r3=0xAA -> r3 reads 0 immediately and the counter is 0.
- Preload the counter via 2^32-1 forced commits (or a backdoor force) -> the next commit wraps oWbCount to 0.
